// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter controller.
// Optional statistics counters are enabled with the ARB_STATS_EN macro.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic PORT0         = 1'b0;
    localparam logic PORT1         = 1'b1;
    localparam int   DEFAULT_DEPTH = 10;
    localparam int   CNT_W         = 16;

    // Addresses at or above the populated depth must never reach the memory.
    function automatic logic addr_out_of_range(input logic [3:0] addr, input int depth);
        return (int'({28'd0, addr}) >= depth);
    endfunction

endpackage

// File: rtl/mem_arb_ctrl_rr_arb2.sv
// Two-input round-robin picker; the last-served pointer advances on every grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_r;

    // Pick a winner; on contention the port not served last wins.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_r == PORT0) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
    end

    // Track the last-served port; reset state favours port 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= PORT1;
        end else if (gnt[0]) begin
            last_r <= PORT0;
        end else if (gnt[1]) begin
            last_r <= PORT1;
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Round-robin controller sharing one single-port memory between two requesters.
// Define ARB_STATS_EN to add per-port completed-access counters cnt0/cnt1.
module mem_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int W     = 7,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [3:0]       addr0,
    input  logic [3:0]       addr1,
    input  logic [W:0]       wdata0,
    input  logic [W:0]       wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [W:0]       rdata0,
    output logic [W:0]       rdata1,
    output logic             err0,
    output logic             err1,
    output logic [W:0]       mem_wdata,
    output logic [3:0]       mem_add,
    output logic             mem_en,
`ifdef ARB_STATS_EN
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
`endif
    input  logic [W:0]       mem_rdata
);

    state_e     state_r;
    logic       port_r;
    logic       we_r;
    logic [1:0] req_s;
    logic [1:0] arb_gnt_s;
    logic       arb_en_s;
    logic       win_s;
    logic       sel_we_s;
    logic [3:0] sel_addr_s;
    logic [W:0] sel_wdata_s;
    logic       reject_s;

    assign req_s    = {req1, req0};
    assign arb_en_s = (state_r == ST_IDLE) && !reset;
    assign gnt0     = arb_gnt_s[0];
    assign gnt1     = arb_gnt_s[1];

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en_s),
        .req   (req_s),
        .gnt   (arb_gnt_s)
    );

    // Route the winning port's request and decide whether it must be rejected.
    always_comb begin
        win_s = arb_gnt_s[1];
        if (win_s == PORT1) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
        // A zero write would look like a read to the memory, so it is refused.
        reject_s = addr_out_of_range(sel_addr_s, DEPTH) || (sel_we_s && (sel_wdata_s == '0));
    end

    // Access sequencer with registered memory command and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            port_r    <= PORT0;
            we_r      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            mem_en    <= 1'b0;
            mem_add   <= 4'd0;
            mem_wdata <= '0;
        end else begin
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            mem_en    <= 1'b0;
            mem_add   <= 4'd0;
            mem_wdata <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_gnt_s != 2'b00) begin
                        port_r <= win_s;
                        we_r   <= sel_we_s;
                        if (reject_s) begin
                            state_r <= ST_RESP;
                            rvalid0 <= (win_s == PORT0);
                            rvalid1 <= (win_s == PORT1);
                            err0    <= (win_s == PORT0);
                            err1    <= (win_s == PORT1);
                        end else begin
                            state_r   <= ST_ISSUE;
                            mem_en    <= 1'b1;
                            mem_add   <= sel_addr_s;
                            mem_wdata <= sel_we_s ? sel_wdata_s : '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (we_r) begin
                        state_r <= ST_RESP;
                        rvalid0 <= (port_r == PORT0);
                        rvalid1 <= (port_r == PORT1);
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state_r <= ST_RESP;
                    if (port_r == PORT1) begin
                        rvalid1 <= 1'b1;
                        rdata1  <= mem_rdata;
                    end else begin
                        rvalid0 <= 1'b1;
                        rdata0  <= mem_rdata;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    // Count completed non-error responses per port, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_r <= '0;
            cnt1_r <= '0;
        end else begin
            if (rvalid0 && !err0 && (cnt0_r != {CNT_W{1'b1}})) begin
                cnt0_r <= cnt0_r + CNT_W'(1);
            end
            if (rvalid1 && !err1 && (cnt1_r != {CNT_W{1'b1}})) begin
                cnt1_r <= cnt1_r + CNT_W'(1);
            end
        end
    end

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;
`endif

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed self-checking bench for mem_arb_ctrl with a behavioural memory.
// Counter checks are compiled in when ARB_STATS_EN is defined.
module tb_mem_arb_ctrl;

    localparam int W = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [W:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_en;
    logic [W:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [3:0] mem_add;
`ifdef ARB_STATS_EN
    logic [15:0] cnt0, cnt1;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W:0] mem_model [0:15];

    always #5 clk = ~clk;

    mem_arb_ctrl #(.W(W), .DEPTH(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .err0      (err0),
        .err1      (err1),
        .mem_wdata (mem_wdata),
        .mem_add   (mem_add),
        .mem_en    (mem_en),
`ifdef ARB_STATS_EN
        .cnt0      (cnt0),
        .cnt1      (cnt1),
`endif
        .mem_rdata (mem_rdata)
    );

    // Single-port memory: nonzero data with mem_en writes, zero data reads (registered).
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wdata != 8'd0) begin
                mem_model[mem_add] <= mem_wdata;
            end else begin
                mem_rdata <= mem_model[mem_add];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic p0_access(input logic we, input logic [3:0] a, input logic [W:0] d, input int cycles);
        req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        tick();
        req0 = 1'b0;
        repeat (cycles - 1) tick();
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'd0; addr1 = 4'd0; wdata0 = 8'd0; wdata1 = 8'd0;
        repeat (3) tick();
        #1;
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        check("rst_err", 32'({err1, err0}), 32'd0);
        check("rst_rdata0", 32'(rdata0), 32'd0);
        req0 = 1'b0;
        reset = 1'b0;
        tick();

        // Port 0 writes 0x5A to address 3.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'h5A;
        #1;
        check("wr_gnt0", 32'(gnt0), 32'd1);
        check("wr_gnt1", 32'(gnt1), 32'd0);
        tick();
        req0 = 1'b0;
        #1;
        check("wr_mem_en", 32'(mem_en), 32'd1);
        check("wr_mem_add", 32'(mem_add), 32'd3);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h5A);
        check("wr_rvalid_early", 32'(rvalid0), 32'd0);
        tick();
        check("wr_rvalid0", 32'(rvalid0), 32'd1);
        check("wr_err0", 32'(err0), 32'd0);
        check("wr_rvalid1", 32'(rvalid1), 32'd0);
        check("wr_mem_en_off", 32'(mem_en), 32'd0);
        tick();

        // Port 1 reads address 3 back.
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3; wdata1 = 8'd0;
        #1;
        check("rd_gnt1", 32'(gnt1), 32'd1);
        check("rd_gnt0", 32'(gnt0), 32'd0);
        tick();
        req1 = 1'b0;
        #1;
        check("rd_mem_en", 32'(mem_en), 32'd1);
        check("rd_mem_add", 32'(mem_add), 32'd3);
        check("rd_mem_wdata", 32'(mem_wdata), 32'd0);
        tick();
        check("rd_wait_mem_en", 32'(mem_en), 32'd0);
        check("rd_wait_rvalid1", 32'(rvalid1), 32'd0);
        tick();
        check("rd_rvalid1", 32'(rvalid1), 32'd1);
        check("rd_rdata1", 32'(rdata1), 32'h5A);
        check("rd_err1", 32'(err1), 32'd0);
        check("rd_rvalid0", 32'(rvalid0), 32'd0);
        tick();

        // Both ports contend for four write accesses: grants alternate 0,1,0,1.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd6; wdata1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_gnt0", 32'(gnt0), 32'((k % 2) == 0));
            check("rr_gnt1", 32'(gnt1), 32'((k % 2) == 1));
            tick();
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            #1;
            check("rr_mem_add", 32'(mem_add), ((k % 2) == 0) ? 32'd5 : 32'd6);
            check("rr_mem_wdata", 32'(mem_wdata), ((k % 2) == 0) ? 32'h11 : 32'h22);
            check("rr_no_gnt_busy", 32'({gnt1, gnt0}), 32'd0);
            tick();
            check("rr_rvalid0", 32'(rvalid0), 32'((k % 2) == 0));
            check("rr_rvalid1", 32'(rvalid1), 32'((k % 2) == 1));
            tick();
        end

        // Port 0 reads out-of-range address 12: error, no memory command.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd12; wdata0 = 8'd0;
        #1;
        check("oob_gnt0", 32'(gnt0), 32'd1);
        tick();
        req0 = 1'b0;
        #1;
        check("oob_rvalid0", 32'(rvalid0), 32'd1);
        check("oob_err0", 32'(err0), 32'd1);
        check("oob_rdata0", 32'(rdata0), 32'd0);
        check("oob_mem_en", 32'(mem_en), 32'd0);
        tick();
        check("oob_done", 32'({rvalid0, mem_en}), 32'd0);

        // Port 0 writes zero to address 2: error, no memory command.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd2; wdata0 = 8'd0;
        #1;
        check("zw_gnt0", 32'(gnt0), 32'd1);
        tick();
        req0 = 1'b0;
        #1;
        check("zw_rvalid0", 32'(rvalid0), 32'd1);
        check("zw_err0", 32'(err0), 32'd1);
        check("zw_mem_en", 32'(mem_en), 32'd0);
        tick();

        // Reset during WAIT of a read drops the access and re-favours port 0.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        #1;
        check("rw_gnt0", 32'(gnt0), 32'd1);
        tick();
        req0 = 1'b0;
        #1;
        check("rw_mem_en", 32'(mem_en), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check("rw_rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rw_rst_mem_en", 32'(mem_en), 32'd0);
        check("rw_rst_rdata0", 32'(rdata0), 32'd0);
        tick();
        check("rw_rst_no_resp", 32'({rvalid1, rvalid0}), 32'd0);
        reset = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd4; wdata0 = 8'h33;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd7; wdata1 = 8'h44;
        #1;
        check("rw_post_gnt0", 32'(gnt0), 32'd1);
        check("rw_post_gnt1", 32'(gnt1), 32'd0);
        tick();
        req0 = 1'b0;
        #1;
        check("rw_post_mem_add", 32'(mem_add), 32'd4);
        tick();
        check("rw_post_rvalid0", 32'(rvalid0), 32'd1);
        tick();
        check("rw_post_gnt1_next", 32'(gnt1), 32'd1);
        tick();
        req1 = 1'b0;
        #1;
        check("rw_post_mem_add1", 32'(mem_add), 32'd7);
        tick();
        tick();

`ifdef ARB_STATS_EN
        // Three good port-0 accesses and one error give cnt0=3, cnt1=0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("cnt0_reset", 32'(cnt0), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            p0_access(1'b1, 4'd1, 8'(8'h10 + i), 3);
        end
        p0_access(1'b0, 4'd15, 8'd0, 2);
        tick();
        check("cnt0", 32'(cnt0), 32'd3);
        check("cnt1", 32'(cnt1), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arb_ctrl.md
Name: mem_arb_ctrl

Overview:
- Two-requester round-robin controller that shares one single-port synchronous memory (W+1-bit data, 4-bit address, DEPTH entries).
- Sequences each access:
  - accept the request;
  - drive the memory command for exactly one cycle;
  - capture the registered read data;
  - return a response to the winning port.
- Guards the memory against out-of-range addresses and zero-valued writes. On this memory, a zero-valued write is indistinguishable from a read.

Parameters:
- W, 7, MSB index of the data word (data width W+1).
- DEPTH, 10, number of valid memory locations; legal addresses are 0..DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request from port 0 / port 1; held until grant.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  4  word address.
- wdata0 / wdata1  in  W+1  write data.
- gnt0 / gnt1  out  1  one-cycle acceptance pulse.
- rvalid0 / rvalid1  out  1  one-cycle response pulse.
- rdata0 / rdata1  out  W+1  read data, valid with rvalid.
- err0 / err1  out  1  request rejected, valid with rvalid.
- mem_wdata  out  W+1  memory write-data bus; nonzero with mem_en means write.
- mem_add  out  4  memory address.
- mem_en  out  1  memory command strobe.
- mem_rdata  in  W+1  memory registered read data, valid one cycle after a read command.

Behaviour:
- Reset:
  - FSM goes to IDLE; RR pointer favours port 0.
  - All outputs are 0: gnt*, rvalid*, rdata*, err*, mem_*.
  - Any in-flight access is dropped; the requester must re-request.
- Request rule:
  - Requester holds req, we, addr and wdata stable until it samples gnt=1 at a rising edge.
  - The controller samples the request in the grant cycle.
- Arbitration (IDLE only):
  - If exactly one req is high, that port wins.
  - If both are high, the port not served last wins, then the pointer toggles.
  - gnt is a Mealy pulse in IDLE; at most one gnt per cycle.
- FSM states:
  - IDLE: on a winner, assert gnt and register port/we/addr/wdata. If addr>=DEPTH, or we=1 with wdata==0, go to RESP with err=1. Otherwise go to ISSUE.
  - ISSUE:
    - Drive mem_add=addr and mem_en=1, for exactly one cycle.
    - mem_wdata=wdata for a write; mem_wdata=0 for a read.
    - Write: go to RESP. Read: go to WAIT.
  - WAIT: mem_en=0; capture mem_rdata at the end of the cycle; go to RESP.
  - RESP:
    - Pulse rvalid of the owning port.
    - rdata = captured data for a read, 0 for a write or an error.
    - err as decided in IDLE. The other port's response outputs stay 0.
    - Go to IDLE.
- Latency from the grant edge:
  - Read: ISSUE at T+1, WAIT at T+2, rvalid at T+3.
  - Write: rvalid at T+2.
  - Error: rvalid at T+1, with no memory command.
- No new grant is issued while not in IDLE. Peak throughput is one access per 3 (write) or 4 (read) cycles.
- mem_* outputs are registered, and are 0 outside ISSUE.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - Adds outputs cnt0 and cnt1 (16 bits each).
  - Each counts completed non-error accesses for its port.
  - Counters saturate at 0xFFFF and are cleared by reset.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, RESP);
  - port ID constants;
  - the default DEPTH;
  - the counter width of 16.
- One sub-module, rr_arb2: 2-input round-robin picker with a registered last-served pointer and an advance enable.

Test Plan:
- Reset, then port 0 writes addr 3, data 0x5A:
  - gnt0 at T, mem_en=1 with mem_add=3 and mem_wdata=0x5A at T+1, rvalid0=1 with err0=0 at T+2.
- Port 1 reads addr 3 after that write: mem_wdata=0 at T+1, rvalid1 at T+3 with rdata1=0x5A.
- req0 and req1 held high together for 4 accesses: grants go 0,1,0,1; no two gnt in one cycle; each rvalid goes to the owning port only.
- Port 0 reads addr 12 (DEPTH=10), then writes 0 to addr 2:
  - err0=1 at T+1 in both cases, and mem_en never asserts.
- Assert reset during WAIT of a read: all outputs 0 immediately, no rvalid, next grant goes to port 0.
- With ARB_STATS_EN, 3 valid accesses on port 0 plus 1 error: cnt0=3, cnt1=0.
